// File: rtl/mem_access_unit.sv
// Data-memory access unit: runs one load/store per accept over a valid/ready
// request channel and a valid response channel, stalling upstream meanwhile.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_in,
  input  logic        is_store_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  rd_in,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        sel_stall,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        align_fault,
  output logic        timeout_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [3:0]         rd_q, rd_d;
  logic               wb_valid_q, wb_valid_d;
  logic [3:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               align_q, align_d;
  logic               tmo_q, tmo_d;
  logic               accept;
  logic               expired;

  // Saturating count; compare with >= so a handshake that wins at the limit
  // still leaves the access bounded in RESP.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    expired = (cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    align_d    = 1'b0;
    tmo_d      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          if (addr_in[1:0] == 2'b00) begin
            accept  = 1'b1;
            addr_d  = addr_in[31:2];
            wdata_d = wdata_in;
            we_d    = is_store_in;
            rd_d    = rd_in;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            align_d = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (dmem_req_ready) begin
          state_d = RESP;
        end else if (expired) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      RESP: begin
        cnt_d = cnt_inc;
        if (dmem_rsp_valid) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = dmem_rdata;
          end
        end else if (expired) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      align_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      align_q    <= align_d;
      tmo_q      <= tmo_d;
    end
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = {addr_q, 2'b00};
  assign dmem_wdata     = wdata_q;
  assign sel_stall      = accept | (state_q != IDLE);
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign align_fault    = align_q;
  assign timeout_fault  = tmo_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the memory-stage controller in the pipelined ARM32 CPU.
- Takes that stage's per-instruction memory request (store enable, effective address, store data, destination register) and runs it against the data memory over a valid/ready request channel and a valid response channel.
- Returns load data to writeback.
- Holds the pipeline with sel_stall while an access is outstanding; flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, cycles an access may stay in REQ plus RESP before it is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_in  in  1  this cycle's instruction needs a data-memory access; sampled only in IDLE.
- is_store_in  in  1  1 = STR (mem_w_en from the memory stage), 0 = LDR.
- addr_in  in  32  effective address from the ALU or the post-indexing path.
- wdata_in  in  32  store data.
- rd_in  in  4  load destination register.
- dmem_req_valid  out  1  request valid to data memory.
- dmem_req_ready  in  1  data memory accepts the request.
- dmem_we  out  1  write enable qualifying the request.
- dmem_addr  out  32  word address; bits [1:0] are always 0.
- dmem_wdata  out  32  store data.
- dmem_rsp_valid  in  1  response or write acknowledge.
- dmem_rdata  in  32  load data, valid with dmem_rsp_valid.
- sel_stall  out  1  freeze the upstream pipeline stages.
- wb_valid  out  1  one-cycle pulse: load data ready for writeback.
- wb_rd  out  4  destination register for wb_valid.
- wb_data  out  32  load data for wb_valid.
- align_fault  out  1  one-cycle pulse: misaligned request rejected.
- timeout_fault  out  1  one-cycle pulse: access aborted by timeout.

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (asynchronous, any state): state = IDLE, counter = 0. All registered outputs go to 0: dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, align_fault, timeout_fault. sel_stall = 0. An in-flight access is dropped silently; late dmem_rsp_valid after reset is ignored.
- Accept (IDLE, req_valid_in = 1, addr_in[1:0] = 0):
  - Register addr_in, wdata_in, is_store_in and rd_in.
  - Next state REQ, counter cleared.
  - sel_stall = 1 combinationally in this same cycle.
- Misaligned (IDLE, req_valid_in = 1, addr_in[1:0] != 0):
  - No request is issued; state stays IDLE.
  - align_fault pulses in the next cycle.
  - sel_stall stays 0.
- REQ:
  - dmem_req_valid = 1; dmem_addr, dmem_we and dmem_wdata are held constant until the handshake.
  - Handshake = dmem_req_valid & dmem_req_ready; on it, next state RESP and dmem_req_valid drops the next cycle.
- RESP:
  - Wait for dmem_rsp_valid. The earliest response is the cycle after the handshake.
  - On the response: next state IDLE.
  - For a load only: wb_valid = 1 in the next cycle, with wb_data = the captured dmem_rdata and wb_rd = the latched rd.
  - A store produces no wb_valid.
- Stall: sel_stall = 1 in the accept cycle and in every cycle in REQ or RESP, including the response cycle. It is 0 in the first IDLE cycle after the response, which is the same cycle wb_valid pulses.
- Back-to-back: a new req_valid_in is accepted in the first IDLE cycle, the same cycle wb_valid pulses for the previous access.
- Timeout:
  - The counter increments every cycle in REQ or RESP and saturates.
  - When the counter reaches TIMEOUT_CYCLES: next state IDLE, dmem_req_valid = 0, timeout_fault pulses in the next cycle, no wb_valid.
  - A handshake or response in the same cycle the limit is reached wins; no fault is raised.
- dmem_rsp_valid outside RESP is ignored. req_valid_in outside IDLE is ignored, because upstream is stalled.
- Pulse outputs (wb_valid, align_fault, timeout_fault) last exactly one cycle. wb_data and wb_rd hold their values until the next load completes.

Test Plan:
- LDR, addr 0x0000_0010: ready on the first REQ cycle, rdata 0xDEAD_BEEF two cycles later -> sel_stall high for 4 cycles; wb_valid pulse with wb_rd = rd_in and wb_data = 0xDEAD_BEEF; dmem_we = 0.
- STR, addr 0x20, wdata 0x1234_5678: ready held low for 3 REQ cycles -> addr, we and wdata stable throughout; dmem_we = 1; no wb_valid after the acknowledge.
- LDR at addr 0x0000_0013 -> align_fault pulses once; dmem_req_valid never asserts; sel_stall stays 0.
- TIMEOUT_CYCLES = 4, ready never asserted -> timeout_fault pulses after 4 REQ/RESP cycles; state back to IDLE; next request accepted normally.
- rst_n pulled low mid-RESP -> all outputs 0 immediately; a response arriving after reset is released produces no wb_valid.
- Two LDRs back-to-back (second req_valid_in presented in the wb_valid cycle) -> second access accepted that cycle; both wb_valid pulses carry the correct rd and data in order.
